// File: rtl/jpu_pkg.sv
// Shared types and constants for the data-side load/store unit.
package jpu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Unshifted byte-enable patterns; lsu_align moves them to the addressed lane.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/lsu_align.sv
// Lane steering for the LSU: byte enables, store-data replication and
// load-data shift with zero/sign extension. Purely combinational.
module lsu_align
  import jpu_pkg::*;
(
  input  mem_size_e   size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rshift;

  assign rshift = rdata_i >> {addr_lo_i, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SZ_BYTE: begin
        be_o    = BE_BYTE << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{signed_i & rshift[7]}}, rshift[7:0]};
      end
      SZ_HALF: begin
        be_o    = BE_HALF << {addr_lo_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{signed_i & rshift[15]}}, rshift[15:0]};
      end
      SZ_WORD: begin
        be_o    = BE_WORD;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
      default: begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
      end
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: single-outstanding req/gnt/rvalid bus master behind the MMU.
// Optional bus watchdog enabled by defining LSU_BUS_TIMEOUT_EN.
module lsu
  import jpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_fault,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  input  logic        bus_err
);

  lsu_state_e  state_q;
  mem_size_e   size_q;
  logic [1:0]  addr_lo_q;
  logic        signed_q;
  logic        we_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic        resp_valid_q, resp_err_q;
  logic [31:0] resp_rdata_q;

  logic        in_idle;
  logic        timeout_hit;
  mem_size_e   al_size;
  logic [1:0]  al_addr_lo;
  logic        al_signed;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_rdata;

  assign in_idle = (state_q == ST_IDLE);

  // The aligner sees the incoming request while idle and the latched one afterwards.
  assign al_size    = in_idle ? mem_size_e'(req_size) : size_q;
  assign al_addr_lo = in_idle ? req_addr[1:0] : addr_lo_q;
  assign al_signed  = in_idle ? req_signed : signed_q;

  lsu_align u_align (
    .size_i    (al_size),
    .addr_lo_i (al_addr_lo),
    .signed_i  (al_signed),
    .wdata_i   (req_wdata),
    .rdata_i   (bus_rdata),
    .be_o      (al_be),
    .wdata_o   (al_wdata),
    .rdata_o   (al_rdata)
  );

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] tmo_cnt_q;

  assign timeout_hit = (state_q == ST_REQ || state_q == ST_WAIT) &&
                       (tmo_cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= '0;
    end else if (in_idle) begin
      tmo_cnt_q <= '0;
    end else if (state_q == ST_REQ || state_q == ST_WAIT) begin
      tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end
  end
`else
  // Watchdog absent: the parameter stays on the interface but never fires.
  assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      size_q       <= SZ_BYTE;
      addr_lo_q    <= 2'b00;
      signed_q     <= 1'b0;
      we_q         <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_we_q     <= 1'b0;
      bus_addr_q   <= '0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            if (req_fault || mem_size_e'(req_size) == SZ_RSVD) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= ST_REQ;
              size_q      <= mem_size_e'(req_size);
              addr_lo_q   <= req_addr[1:0];
              signed_q    <= req_signed;
              we_q        <= req_we;
              bus_req_q   <= 1'b1;
              bus_we_q    <= req_we;
              bus_addr_q  <= {req_addr[31:2], 2'b00};
              bus_be_q    <= al_be;
              bus_wdata_q <= al_wdata;
            end
          end
        end
        ST_REQ: begin
          if (timeout_hit || bus_gnt) begin
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            if (timeout_hit) begin
              state_q      <= ST_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (timeout_hit) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else if (bus_rvalid) begin
            state_q      <= ST_RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= bus_err;
            resp_rdata_q <= (bus_err || we_q) ? 32'd0 : al_rdata;
          end
        end
        default: begin
          state_q      <= ST_IDLE;
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          resp_rdata_q <= '0;
        end
      endcase
    end
  end

  assign req_ready  = in_idle;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign bus_req    = bus_req_q;
  assign bus_we     = bus_we_q;
  assign bus_addr   = bus_addr_q;
  assign bus_be     = bus_be_q;
  assign bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: cycle-level expectation model plus literal pins.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_we = 1'b0, req_signed = 1'b0, req_fault = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt = 1'b0, bus_rvalid = 1'b0, bus_err = 1'b0;
  logic [31:0] bus_rdata = '0;

  always #5 clk = ~clk;

  lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_fault(req_fault),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Expected DUT outputs for the current cycle, updated by the stimulus tasks.
  bit          chk_en = 1'b0;
  bit          m_ready = 1'b1, m_bus_req = 1'b0, m_we = 1'b0, m_resp = 1'b0, m_err = 1'b0;
  logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;
  logic [3:0]  m_be = '0;

  logic [31:0] cap_addr = '0, cap_wdata = '0, cap_rdata = '0;
  logic [3:0]  cap_be = '0;
  logic        cap_err = 1'b0;
  int          resp_cyc = 0;
  int          breq_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference rules: lane arithmetic on plain integers.
  function automatic logic [3:0] mdl_be(input int size, input int a);
    case (size)
      0:       return 4'(1 << a);
      1:       return 4'(3 << ((a / 2) * 2));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] mdl_wdata(input int size, input logic [31:0] d);
    int n;
    logic [31:0] r;
    n = (size == 0) ? 1 : (size == 1) ? 2 : 4;
    r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = d[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] mdl_load(input int size, input bit sgn, input int a, input logic [31:0] rd);
    longint v;
    int bits;
    if (size == 2) return rd;
    bits = (size == 0) ? 8 : 16;
    v = longint'(rd >> (8 * a)) & ((longint'(1) << bits) - 1);
    if (sgn && v >= (longint'(1) << (bits - 1))) v = v - (longint'(1) << bits);
    return v[31:0];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("req_ready", {31'd0, req_ready}, {31'd0, m_ready});
      check("bus_req", {31'd0, bus_req}, {31'd0, m_bus_req});
      if (m_bus_req) begin
        check("bus_we", {31'd0, bus_we}, {31'd0, m_we});
        check("bus_addr", bus_addr, m_addr);
        check("bus_be", {28'd0, bus_be}, {28'd0, m_be});
        if (m_we) check("bus_wdata", bus_wdata, m_wdata);
      end
      if (bus_req) begin
        breq_cycles++;
        cap_addr  = bus_addr;
        cap_be    = bus_be;
        cap_wdata = bus_wdata;
      end
      check("resp_valid", {31'd0, resp_valid}, {31'd0, m_resp});
      if (m_resp) begin
        check("resp_err", {31'd0, resp_err}, {31'd0, m_err});
        check("resp_rdata", resp_rdata, m_rdata);
      end
      if (resp_valid) begin
        resp_cyc  = cyc;
        cap_rdata = resp_rdata;
        cap_err   = resp_err;
      end
    end
  end

  task automatic scramble();
    req_we     = 1'($urandom);
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_fault  = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  // Called just after a rising edge; returns accept-to-response latency in cycles.
  task automatic txn(input bit we, input int size, input bit sgn, input logic [31:0] addr,
                     input logic [31:0] wd, input bit flt, input int gnt_dly, input int rv_dly,
                     input logic [31:0] rd, input bit berr, output int lat);
    int acc;
    breq_cycles = 0;
    req_valid = 1'b1; req_we = we; req_size = 2'(size); req_signed = sgn;
    req_addr = addr; req_wdata = wd; req_fault = flt;
    acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    if (flt || size == 3) begin
      m_ready = 1'b0; m_resp = 1'b1; m_err = 1'b1; m_rdata = '0;
      @(posedge clk); #1;
      m_resp = 1'b0; m_ready = 1'b1;
    end else begin
      m_ready = 1'b0; m_bus_req = 1'b1; m_we = we;
      m_addr = {addr[31:2], 2'b00};
      m_be = mdl_be(size, int'(addr[1:0]));
      m_wdata = mdl_wdata(size, wd);
      repeat (gnt_dly) begin @(posedge clk); #1; scramble(); end
      bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus_gnt = 1'b0; m_bus_req = 1'b0;
      repeat (rv_dly) begin @(posedge clk); #1; end
      bus_rvalid = 1'b1; bus_rdata = rd; bus_err = berr;
      @(posedge clk); #1;
      bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
      m_resp = 1'b1; m_err = berr;
      m_rdata = (berr || we) ? 32'd0 : mdl_load(size, sgn, int'(addr[1:0]), rd);
      @(posedge clk); #1;
      m_resp = 1'b0; m_ready = 1'b1;
    end
    lat = resp_cyc - acc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_be", {28'd0, bus_be}, 32'd0);
    check("rst_bus_wdata", bus_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // Signed byte load from the top lane.
    txn(1'b0, 0, 1'b1, 32'h0000_1003, 32'h0, 1'b0, 0, 0, 32'h80FF_FF12, 1'b0, lat);
    check("lb_addr", cap_addr, 32'h0000_1000);
    check("lb_be", {28'd0, cap_be}, 32'h8);
    check("lb_rdata", cap_rdata, 32'hFFFF_FF80);
    check("lb_err", {31'd0, cap_err}, 32'd0);
    check("lb_latency", lat, 3);

    // Half store to the upper half, immediate grant.
    txn(1'b1, 1, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 1'b0, 0, 0, 32'h0, 1'b0, lat);
    check("sh_be", {28'd0, cap_be}, 32'hC);
    check("sh_wdata", cap_wdata, 32'hABCD_ABCD);
    check("sh_rdata", cap_rdata, 32'd0);
    check("sh_latency", lat, 3);

    // MMU fault and reserved size: one-cycle error, no bus traffic.
    txn(1'b0, 2, 1'b0, 32'h0000_4001, 32'h0, 1'b1, 0, 0, 32'h0, 1'b0, lat);
    check("fault_latency", lat, 1);
    check("fault_err", {31'd0, cap_err}, 32'd1);
    check("fault_no_bus", breq_cycles, 0);
    txn(1'b0, 3, 1'b0, 32'h0000_5000, 32'h0, 1'b0, 0, 0, 32'h0, 1'b0, lat);
    check("rsvd_latency", lat, 1);
    check("rsvd_err", {31'd0, cap_err}, 32'd1);
    check("rsvd_no_bus", breq_cycles, 0);

    // Word load, grant after 4 waits, bus error; next access back-to-back.
    txn(1'b0, 2, 1'b0, 32'h0000_6000, 32'h0, 1'b0, 4, 0, 32'hDEAD_BEEF, 1'b1, lat);
    check("berr_err", {31'd0, cap_err}, 32'd1);
    check("berr_rdata", cap_rdata, 32'd0);
    check("berr_latency", lat, 7);
    check("berr_req_cycles", breq_cycles, 5);
    txn(1'b0, 1, 1'b0, 32'h0000_7002, 32'h0, 1'b0, 0, 2, 32'h8765_4321, 1'b0, lat);
    check("lhu_rdata", cap_rdata, 32'h0000_8765);
    check("lhu_latency", lat, 5);
    txn(1'b0, 1, 1'b1, 32'h0000_7002, 32'h0, 1'b0, 1, 0, 32'h8765_4321, 1'b0, lat);
    check("lh_rdata", cap_rdata, 32'hFFFF_8765);
    txn(1'b0, 0, 1'b0, 32'h0000_7001, 32'h0, 1'b0, 0, 0, 32'h1234_F600, 1'b0, lat);
    check("lbu_rdata", cap_rdata, 32'h0000_00F6);
    check("lbu_be", {28'd0, cap_be}, 32'h2);
    txn(1'b1, 0, 1'b0, 32'h0000_8001, 32'hFFFF_FF5A, 1'b0, 2, 1, 32'h0, 1'b0, lat);
    check("sb_wdata", cap_wdata, 32'h5A5A_5A5A);
    check("sb_be", {28'd0, cap_be}, 32'h2);
    txn(1'b1, 2, 1'b0, 32'h0000_9000, 32'h1357_9BDF, 1'b0, 0, 0, 32'h0, 1'b0, lat);
    check("sw_wdata", cap_wdata, 32'h1357_9BDF);
    txn(1'b0, 2, 1'b1, 32'h0000_A000, 32'h0, 1'b0, 0, 0, 32'hCAFE_F00D, 1'b0, lat);
    check("lw_rdata", cap_rdata, 32'hCAFE_F00D);

    // Reset while waiting for the read response.
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_fault = 1'b0; req_addr = 32'h0000_B000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_ready = 1'b0; m_bus_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_B000; m_be = 4'hF;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; m_bus_req = 1'b0;
    chk_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
    check("mid_rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_ready = 1'b1; m_resp = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    txn(1'b0, 2, 1'b0, 32'h0000_C000, 32'h0, 1'b0, 1, 1, 32'h0BAD_F00D, 1'b0, lat);
    check("post_rst_rdata", cap_rdata, 32'h0BAD_F00D);
    check("post_rst_latency", lat, 5);

`ifdef LSU_BUS_TIMEOUT_EN
    // Grant never arrives: watchdog closes the access after 8 cycles in REQ.
    breq_cycles = 0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_fault = 1'b0; req_addr = 32'h0000_D000;
    lat = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
    m_ready = 1'b0; m_bus_req = 1'b1; m_we = 1'b0; m_addr = 32'h0000_D000; m_be = 4'hF;
    repeat (8) begin @(posedge clk); #1; end
    m_bus_req = 1'b0; m_resp = 1'b1; m_err = 1'b1; m_rdata = '0;
    @(posedge clk); #1;
    m_resp = 1'b0; m_ready = 1'b1;
    check("tmo_latency", resp_cyc - lat, 9);
    check("tmo_req_cycles", breq_cycles, 8);
    check("tmo_err", {31'd0, cap_err}, 32'd1);
    bus_rvalid = 1'b1; bus_rdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
`endif

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly downstream of the MMU on the data side. Accepts one physical data access per transaction from the memory pipeline stage, together with the MMU's address-error fault. Drives a single-outstanding request/grant/response memory bus with byte enables. Returns load data aligned and sign/zero-extended to 32 bits, or an error response.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255, bus watchdog limit in cycles; used only with LSU_BUS_TIMEOUT_EN.

Ports (clk/rst_n: one clock; reset is asynchronous and active-low):
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  pipeline presents an access
- req_ready  out  1  LSU can accept an access
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  mem_size_e: 0 byte, 1 half, 2 word, 3 reserved
- req_signed  in  1  sign-extend load result
- req_addr  in  32  physical address (MMU data_addr_phy)
- req_wdata  in  32  store data, right-justified
- req_fault  in  1  MMU address error (AdEL or AdES) for this access
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  access failed (fault, reserved size, bus error, timeout)
- bus_req  out  1  bus request
- bus_we  out  1  bus write
- bus_addr  out  32  word address, {req_addr[31:2],2'b00}
- bus_be  out  4  byte enables
- bus_wdata  out  32  lane-replicated store data
- bus_gnt  in  1  request accepted this cycle
- bus_rvalid  in  1  response (read data or write ack)
- bus_rdata  in  32  read data
- bus_err  in  1  bus error, qualified by bus_rvalid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP. req_ready = (state == IDLE).
- IDLE: on req_valid: if req_fault or req_size==3 -> RESP with err=1, no bus activity; else latch addr/size/signed/we/wdata, -> REQ.
- REQ: bus_req=1 with stable bus_* outputs; on bus_gnt -> WAIT.
- WAIT: on bus_rvalid, capture rdata/bus_err -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Byte enables (little-endian): byte 4'b0001<<addr[1:0]; half 4'b0011<<{addr[1],1'b0}; word 4'hF. Misalignment is the MMU's concern; LSU uses addr[1:0] as given.
- Store data: byte replicated to all 4 lanes, half to both halves, word unchanged.
- Load: shift bus_rdata right by 8*addr[1:0]; byte/half zero- or sign-extended per req_signed; word passed through.
- Stores also wait for bus_rvalid (write ack); resp_rdata=0.
- bus_err=1 with rvalid -> resp_err=1, resp_rdata=0.
- Inputs other than req_valid are ignored outside IDLE.

## Timing
- Reset: state IDLE; req_ready=1 after reset release; resp_valid, resp_err, resp_rdata, bus_req, bus_we, bus_addr, bus_be, bus_wdata all 0.
- Accept at cycle 0 -> bus_req at cycle 1 (registered). gnt in cycle 1 -> earliest rvalid cycle 2 -> resp_valid cycle 3. Minimum load/store latency 3 cycles; fault/reserved latency 1 cycle.
- bus_gnt and bus_rvalid in the same cycle are not legal; rvalid is honoured only in WAIT.
- req_ready low from cycle after accept until cycle after resp_valid; back-to-back accept in the cycle following RESP.
- Reset mid-transaction: all outputs drop asynchronously, transaction discarded, no resp_valid.

## Configuration
- LSU_BUS_TIMEOUT_EN defined: counter cleared on entering REQ, increments in REQ and WAIT; on reaching TIMEOUT_CYCLES, bus_req drops, -> RESP with resp_err=1. A later stray bus_rvalid in IDLE is ignored.
- Undefined: no counter; LSU waits indefinitely in REQ/WAIT; TIMEOUT_CYCLES unused.

## Structure
- jpu_pkg: mem_size_e enum, lsu_state_e enum, lane/byte-enable helper constants.
- Sub-module lsu_align: combinational byte-enable generation, store lane replication, and load shift/extend; FSM and registers live in lsu.

## Test plan
- Load byte signed, addr 0x1003, bus_rdata 0x80FF_FF12 -> bus_addr 0x1000, be 4'b1000, resp_rdata 0xFFFF_FF80, resp_err 0.
- Store half, addr 0x2002, wdata 0x0000_ABCD, gnt immediate -> be 4'b1100, bus_wdata 0xABCD_ABCD, resp_valid 3 cycles after accept, rdata 0.
- req_fault=1 on load -> no bus_req, resp_valid next cycle with resp_err=1; req_size=3 gives the same.
- Word load, gnt after 4 wait cycles, rvalid with bus_err=1 -> resp_err=1, resp_rdata 0, req_ready high next cycle.
- With LSU_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, gnt never asserted -> bus_req drops, resp_err=1 after 8 cycles in REQ.
- rst_n low while in WAIT -> bus_req/resp_valid 0 immediately; after release, new word load completes normally.
